// File: rtl/sdram_rw_test.sv
// ---------------------------------------------------------------------------
// sdram_rw_test
//   Self-checking traffic generator / checker for the user FIFO ports of
//   sdram_top. Once SDRAM init completes it writes an incrementing pattern
//   1..DATA_LEN through the write FIFO, waits for the data to drain into the
//   SDRAM, enables SDRAM reads, reads the pattern back through the read FIFO
//   and compares every word. Results drive the board LED and debug logic.
//
// Ports
//   clk               in   single clock (also sdram_top wr_clk / rd_clk)
//   rst_n             in   asynchronous active-low reset
//   sdram_init_done   in   SDRAM init complete (asynchronous to this logic)
//   wr_en             out  write FIFO enable
//   wr_data[15:0]     out  write FIFO data
//   rd_en             out  read FIFO enable
//   rd_data[15:0]     in   read FIFO data, valid RD_LAT cycles after rd_en
//   sdram_read_valid  out  SDRAM read enable towards sdram_top
//   test_done         out  checker finished
//   test_pass         out  finished with zero mismatches
//   err_flag          out  sticky, set on the first mismatch
//   err_cnt[15:0]     out  mismatch count, saturating at 16'hFFFF
//
// All outputs are registered. DRAIN_DLY counts from the last write cycle to
// the first cycle with sdram_read_valid high, so it should be at least 2.
// ---------------------------------------------------------------------------
module sdram_rw_test #(
  parameter int unsigned DATA_LEN    = 1024,    // 1..65535 words
  parameter logic [15:0] START_DLY   = 16'd200,
  parameter logic [15:0] DRAIN_DLY   = 16'd2000,
  parameter logic [15:0] PREFILL_DLY = 16'd500,
  parameter int unsigned RD_LAT      = 1        // 1..2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        rd_en,
  input  logic [15:0] rd_data,
  output logic        sdram_read_valid,
  output logic        test_done,
  output logic        test_pass,
  output logic        err_flag,
  output logic [15:0] err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_WAIT,
    S_WRITE,
    S_DRAIN,
    S_PREFILL,
    S_READ,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [15:0] LAST_IDX  = 16'(DATA_LEN - 1);
  localparam logic [15:0] RD_LAT_W  = 16'(RD_LAT);
  localparam int unsigned CMP_STAGE = RD_LAT - 1;

  // -------------------------------------------------------------------------
  // init_done synchronizer
  // -------------------------------------------------------------------------
  logic r_sync_meta;
  logic r_init_s;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_meta <= 1'b0;
      r_init_s    <= 1'b0;
    end else begin
      r_sync_meta <= sdram_init_done;
      r_init_s    <= r_sync_meta;
    end
  end

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  state_t      r_state;
  logic [15:0] r_dly_cnt;
  logic [15:0] r_word_cnt;
  logic        r_wr_en;
  logic [15:0] r_wr_data;
  logic        r_rd_en;
  logic        r_rd_valid;
  logic        r_done;
  logic        r_pass;
  logic        r_err_flag;
  logic [15:0] r_err_cnt;

  // Expected-value pipeline: one stage per cycle of read latency.
  logic        r_exp_vld [RD_LAT];
  logic [15:0] r_exp_dat [RD_LAT];

  // -------------------------------------------------------------------------
  // Compare and abort detection
  // -------------------------------------------------------------------------
  logic w_cmp_vld;
  logic w_mismatch;
  logic w_abort;

  assign w_cmp_vld  = r_exp_vld[CMP_STAGE];
  assign w_mismatch = w_cmp_vld && (rd_data != r_exp_dat[CMP_STAGE]);
  // Losing init anywhere mid-run restarts the test; IDLE is already idle and
  // DONE keeps its result for the LEDs until reset.
  assign w_abort    = !r_init_s && (r_state != S_IDLE) && (r_state != S_DONE);

  // -------------------------------------------------------------------------
  // Next-state / next-output logic
  // -------------------------------------------------------------------------
  state_t      w_state_nxt;
  logic [15:0] w_dly_nxt;
  logic [15:0] w_word_nxt;
  logic        w_wr_en_nxt;
  logic [15:0] w_wr_data_nxt;
  logic        w_rd_en_nxt;
  logic        w_rd_valid_nxt;
  logic        w_done_nxt;
  logic        w_pass_nxt;
  logic        w_err_flag_nxt;
  logic [15:0] w_err_cnt_nxt;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    w_state_nxt    = r_state;
    w_dly_nxt      = r_dly_cnt;
    w_word_nxt     = r_word_cnt;
    w_wr_en_nxt    = 1'b0;
    w_wr_data_nxt  = r_wr_data;
    w_rd_en_nxt    = 1'b0;
    w_rd_valid_nxt = r_rd_valid;
    w_done_nxt     = r_done;
    w_pass_nxt     = r_pass;
    w_err_flag_nxt = r_err_flag;
    w_err_cnt_nxt  = r_err_cnt;

    if (w_mismatch) begin
      w_err_flag_nxt = 1'b1;
      if (r_err_cnt != 16'hFFFF) begin
        w_err_cnt_nxt = r_err_cnt + 16'd1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (r_init_s) begin
          w_state_nxt = S_START_WAIT;
          w_dly_nxt   = '0;
          w_word_nxt  = '0;
        end
      end

      S_START_WAIT: begin
        if (r_dly_cnt + 16'd1 >= START_DLY) begin
          // wr_en and the first word are registered on entry to WRITE.
          w_state_nxt   = S_WRITE;
          w_dly_nxt     = '0;
          w_word_nxt    = '0;
          w_wr_en_nxt   = 1'b1;
          w_wr_data_nxt = 16'd1;
        end else begin
          w_dly_nxt = r_dly_cnt + 16'd1;
        end
      end

      S_WRITE: begin
        if (r_word_cnt == LAST_IDX) begin
          // wr_data keeps the last word while wr_en drops.
          w_state_nxt = S_DRAIN;
          w_dly_nxt   = '0;
        end else begin
          w_wr_en_nxt   = 1'b1;
          w_word_nxt    = r_word_cnt + 16'd1;
          w_wr_data_nxt = r_wr_data + 16'd1;
        end
      end

      S_DRAIN: begin
        // The cycle after the last write is the first drain cycle, so the
        // state itself lasts DRAIN_DLY-1 cycles before read_valid registers.
        if ({1'b0, r_dly_cnt} + 17'd2 >= {1'b0, DRAIN_DLY}) begin
          w_state_nxt    = S_PREFILL;
          w_dly_nxt      = '0;
          w_rd_valid_nxt = 1'b1;
        end else begin
          w_dly_nxt = r_dly_cnt + 16'd1;
        end
      end

      S_PREFILL: begin
        if (r_dly_cnt + 16'd1 >= PREFILL_DLY) begin
          w_state_nxt = S_READ;
          w_dly_nxt   = '0;
          w_word_nxt  = '0;
          w_rd_en_nxt = 1'b1;
        end else begin
          w_dly_nxt = r_dly_cnt + 16'd1;
        end
      end

      S_READ: begin
        if (r_word_cnt == LAST_IDX) begin
          w_state_nxt = S_FLUSH;
          w_dly_nxt   = '0;
        end else begin
          w_rd_en_nxt = 1'b1;
          w_word_nxt  = r_word_cnt + 16'd1;
        end
      end

      S_FLUSH: begin
        if (r_dly_cnt + 16'd1 >= RD_LAT_W) begin
          // The last compare lands in this cycle; its update is visible in
          // w_err_cnt_nxt, so pass is decided on the final count.
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_err_cnt_nxt == 16'd0);
        end else begin
          w_dly_nxt = r_dly_cnt + 16'd1;
        end
      end

      S_DONE: begin
        // Result held until reset.
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_abort) begin
      w_state_nxt    = S_IDLE;
      w_dly_nxt      = '0;
      w_word_nxt     = '0;
      w_wr_en_nxt    = 1'b0;
      w_wr_data_nxt  = '0;
      w_rd_en_nxt    = 1'b0;
      w_rd_valid_nxt = 1'b0;
      w_done_nxt     = 1'b0;
      w_pass_nxt     = 1'b0;
      w_err_flag_nxt = 1'b0;
      w_err_cnt_nxt  = '0;
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_dly_cnt  <= '0;
      r_word_cnt <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_rd_en    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_dly_cnt  <= w_dly_nxt;
      r_word_cnt <= w_word_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
      r_err_flag <= w_err_flag_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Expected-value pipeline: stage 0 captures the index of each issued read
  // (as the word value k+1); the last stage lines up with rd_data.
  // -------------------------------------------------------------------------
  // NOTE: this small array is reset because its valid bits gate the compare;
  // a stale valid after reset would count a spurious mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        r_exp_vld[i] <= 1'b0;
        r_exp_dat[i] <= '0;
      end
    end else if (w_abort) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        r_exp_vld[i] <= 1'b0;
        r_exp_dat[i] <= '0;
      end
    end else begin
      r_exp_vld[0] <= r_rd_en;
      r_exp_dat[0] <= r_word_cnt + 16'd1;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_exp_vld[i] <= r_exp_vld[i-1];
        r_exp_dat[i] <= r_exp_dat[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign wr_en            = r_wr_en;
  assign wr_data          = r_wr_data;
  assign rd_en            = r_rd_en;
  assign sdram_read_valid = r_rd_valid;
  assign test_done        = r_done;
  assign test_pass        = r_pass;
  assign err_flag         = r_err_flag;
  assign err_cnt          = r_err_cnt;

endmodule

// File: tb/tb_sdram_rw_test.sv
// ---------------------------------------------------------------------------
// tb_sdram_rw_test
//   Bench for sdram_rw_test. Two instances: a DATA_LEN=8 / RD_LAT=1 unit
//   with short delays driven through a vector table, random corruption runs,
//   abort and reset sequences; and a DATA_LEN=1 / RD_LAT=2 unit for the
//   single-word corner. Each unit talks to an ideal FIFO model (a queue)
//   that can substitute corrupted words on chosen read indices.
// ---------------------------------------------------------------------------
module tb_sdram_rw_test;

  localparam int T_LEN   = 8;
  localparam int T_START = 4;
  localparam int T_DRAIN = 10;
  localparam int T_PRE   = 3;
  localparam int T_LAT   = 1;
  localparam int SYNC_IDLE = 3;   // two synchronizer flops + one IDLE cycle

  logic clk;
  logic rst_n;

  // unit A signals
  logic        sdram_init_done;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        sdram_read_valid;
  logic        test_done;
  logic        test_pass;
  logic        err_flag;
  logic [15:0] err_cnt;

  // unit B signals
  logic        init_1;
  logic        wr_en_1;
  logic [15:0] wr_data_1;
  logic        rd_en_1;
  logic [15:0] rd_data_1;
  logic        rv_1;
  logic        done_1;
  logic        pass_1;
  logic        flag_1;
  logic [15:0] err_cnt_1;

  sdram_rw_test #(
    .DATA_LEN(T_LEN), .START_DLY(16'(T_START)), .DRAIN_DLY(16'(T_DRAIN)),
    .PREFILL_DLY(16'(T_PRE)), .RD_LAT(T_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
    .sdram_read_valid(sdram_read_valid), .test_done(test_done),
    .test_pass(test_pass), .err_flag(err_flag), .err_cnt(err_cnt)
  );

  sdram_rw_test #(
    .DATA_LEN(1), .START_DLY(16'(T_START)), .DRAIN_DLY(16'(T_DRAIN)),
    .PREFILL_DLY(16'(T_PRE)), .RD_LAT(2)
  ) dut_1 (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(init_1),
    .wr_en(wr_en_1), .wr_data(wr_data_1), .rd_en(rd_en_1), .rd_data(rd_data_1),
    .sdram_read_valid(rv_1), .test_done(done_1),
    .test_pass(pass_1), .err_flag(flag_1), .err_cnt(err_cnt_1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Ideal FIFO model for unit A with per-index corruption. Also checks that
  // err_flag is still low while the first bad word is on rd_data and high
  // one cycle later.
  // -------------------------------------------------------------------------
  logic [7:0]  corrupt_mask;
  logic [15:0] corrupt_val [8];
  logic        model_clr;
  logic [15:0] q_a [$];
  int          rd_idx_a;
  bit          pend_a;
  bit          first_bad_a;

  always @(posedge clk) begin : model_a
    logic [15:0] word;
    bit got;
    bit bad;
    got  = 1'b0;
    bad  = 1'b0;
    word = '0;
    if (!rst_n || model_clr) begin
      q_a.delete();
      rd_idx_a    = 0;
      pend_a      = 1'b0;
      first_bad_a = 1'b0;
    end else begin
      if (wr_en) q_a.push_back(wr_data);
      if (rd_en) begin
        word = (q_a.size() > 0) ? q_a.pop_front() : 16'hDEAD;
        if (rd_idx_a < 8 && corrupt_mask[rd_idx_a]) word = corrupt_val[rd_idx_a];
        got = 1'b1;
        rd_idx_a++;
        bad = (word != 16'(rd_idx_a));   // k-th read must return k+1
      end
    end
    #1;
    if (pend_a) begin
      check("err_flag_after_compare", int'(err_flag), 1);
      pend_a = 1'b0;
    end
    if (got) begin
      rd_data = word;
      if (bad && !first_bad_a) begin
        check("err_flag_during_compare", int'(err_flag), 0);
        first_bad_a = 1'b1;
        pend_a      = 1'b1;
      end
    end
  end

  // Ideal FIFO model for unit B, two cycles of read latency.
  logic [15:0] q_b [$];
  bit          hold_b_v;
  logic [15:0] hold_b_d;

  always @(posedge clk) begin : model_b
    logic [15:0] out_d;
    bit out_v;
    out_v = hold_b_v;
    out_d = hold_b_d;
    if (!rst_n) begin
      q_b.delete();
      hold_b_v = 1'b0;
      out_v    = 1'b0;
    end else begin
      if (wr_en_1) q_b.push_back(wr_data_1);
      hold_b_v = rd_en_1;
      if (rd_en_1) hold_b_d = (q_b.size() > 0) ? q_b.pop_front() : 16'hDEAD;
    end
    #1;
    if (out_v) rd_data_1 = out_d;
  end

  always @(negedge clk) begin
    if ((wr_en && rd_en) || (wr_en_1 && rd_en_1)) overlap++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Sequence helpers (all start and end on a falling edge)
  // -------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sdram_init_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctl", int'({wr_en, rd_en, sdram_read_valid, test_done, test_pass, err_flag}), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    rst_n = 1'b1;
  endtask

  // Called on the falling edge where init (or rst_n release) took effect.
  task automatic wait_first_wr(input string tag);
    int n;
    n = 0;
    while (!wr_en && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_first_wr_lat"}, n, SYNC_IDLE + T_START);
  endtask

  task automatic finish_run(input string tag, input int exp_err, input int exp_pass);
    int idx;
    int bad;
    int n;
    idx = 0;
    bad = 0;
    while (wr_en && idx < 4 * T_LEN) begin
      if (wr_data != 16'(idx + 1)) bad++;
      idx++;
      @(negedge clk);
    end
    check({tag, "_wr_count"}, idx, T_LEN);
    check({tag, "_wr_data_bad"}, bad, 0);
    check({tag, "_wr_hold"}, int'(wr_data), T_LEN);
    n = 1;
    while (!sdram_read_valid && n < 4 * T_DRAIN) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_lat"}, n, T_DRAIN);
    n = 0;
    while (!rd_en && n < 4 * T_PRE + 4) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_prefill_lat"}, n, T_PRE);
    idx = 0;
    bad = 0;
    while (rd_en && idx < 4 * T_LEN) begin
      if (!sdram_read_valid) bad++;
      idx++;
      @(negedge clk);
    end
    check({tag, "_rd_count"}, idx, T_LEN);
    check({tag, "_rv_held"}, bad, 0);
    n = 1;
    while (!test_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_lat"}, n, T_LAT + 1);
    check({tag, "_err_cnt"}, int'(err_cnt), exp_err);
    check({tag, "_test_pass"}, int'(test_pass), exp_pass);
    check({tag, "_err_flag"}, int'(err_flag), (exp_err != 0) ? 1 : 0);
    check({tag, "_rv_done"}, int'(sdram_read_valid), 1);
  endtask

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct {
    string      name;
    logic [7:0] mask;
    int         exp_err;
    int         exp_pass;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    logic [7:0] m;
    rst_n = 1'b1;
    sdram_init_done = 1'b0;
    init_1 = 1'b0;
    model_clr = 1'b0;
    rd_data = '0;
    rd_data_1 = '0;
    corrupt_mask = '0;
    for (int i = 0; i < 8; i++) corrupt_val[i] = '0;

    vecs[0] = '{"nominal",    8'h00, 0, 1};
    vecs[1] = '{"word5_zero", 8'h10, 1, 0};
    vecs[2] = '{"all_zero",   8'hFF, 8, 0};
    vecs[3] = '{"first_last", 8'h81, 2, 0};
    vecs[4] = '{"alternate",  8'h55, 4, 0};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      corrupt_mask = vecs[v].mask;
      for (int i = 0; i < 8; i++) corrupt_val[i] = 16'h0000;
      sdram_init_done = 1'b1;
      wait_first_wr(vecs[v].name);
      finish_run(vecs[v].name, vecs[v].exp_err, vecs[v].exp_pass);
      if (v == 0) begin
        // An init fall in DONE must not disturb the result.
        sdram_init_done = 1'b0;
        repeat (6) @(negedge clk);
        check("done_hold_done", int'(test_done), 1);
        check("done_hold_pass", int'(test_pass), 1);
        check("done_hold_rv", int'(sdram_read_valid), 1);
      end
    end

    // Random corruption patterns with random start gaps.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      m = 8'($urandom_range(0, 255));
      corrupt_mask = m;
      for (int i = 0; i < 8; i++)
        corrupt_val[i] = 16'(i + 1) ^ 16'($urandom_range(1, 65535));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      sdram_init_done = 1'b1;
      wait_first_wr("rand");
      finish_run("rand", $countones(m), (m == 8'h00) ? 1 : 0);
    end

    // Abort during READ, then a clean rerun without reset.
    do_reset();
    corrupt_mask = 8'hFF;
    for (int i = 0; i < 8; i++) corrupt_val[i] = 16'h0000;
    sdram_init_done = 1'b1;
    wait_first_wr("abort");
    n = 0;
    while (!rd_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_read", int'(rd_en), 1);
    repeat (2) @(negedge clk);
    sdram_init_done = 1'b0;
    repeat (2) @(negedge clk);
    // Still reading while the fall crosses the synchronizer; the first
    // three reads have been compared and counted by now.
    check("abort_pre_rd_en", int'(rd_en), 1);
    check("abort_pre_err_cnt", int'(err_cnt), 3);
    @(negedge clk);
    check("abort_rd_en", int'(rd_en), 0);
    check("abort_rv", int'(sdram_read_valid), 0);
    check("abort_err_cnt", int'(err_cnt), 0);
    check("abort_err_flag", int'(err_flag), 0);
    corrupt_mask = 8'h00;
    model_clr = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
    sdram_init_done = 1'b1;
    wait_first_wr("rerun");
    finish_run("rerun", 0, 1);

    // Reset pulse in the middle of WRITE.
    do_reset();
    sdram_init_done = 1'b1;
    wait_first_wr("midrst");
    repeat (3) @(negedge clk);
    check("midrst_wr_data_before", int'(wr_data), 4);
    rst_n = 1'b0;
    #1;
    check("midrst_async_ctl", int'({wr_en, rd_en, sdram_read_valid, test_done, test_pass, err_flag}), 0);
    check("midrst_async_data", int'(wr_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_first_wr("midrst_restart");
    check("midrst_first_word", int'(wr_data), 1);
    finish_run("midrst_restart", 0, 1);

    // Single-word unit with two cycles of read latency.
    do_reset();
    init_1 = 1'b1;
    n = 0;
    while (!wr_en_1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("len1_first_wr_lat", n, SYNC_IDLE + T_START);
    check("len1_wr_data", int'(wr_data_1), 1);
    @(negedge clk);
    check("len1_single_write", int'(wr_en_1), 0);
    n = 0;
    while (!rd_en_1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("len1_rd_seen", int'(rd_en_1), 1);
    @(negedge clk);
    check("len1_single_read", int'(rd_en_1), 0);
    n = 1;
    while (!done_1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("len1_done_lat", n, 3);
    check("len1_pass", int'(pass_1), 1);
    check("len1_err_cnt", int'(err_cnt_1), 0);
    check("len1_rv", int'(rv_1), 1);

    check("no_wr_rd_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
